// File: rtl/cve2_pkg.sv
// Shared type definitions for the cve2 execute-stage blocks.
package cve2_pkg;

  // Which multiply/divide implementation the core provides.
  typedef enum integer {
    RV32MNone        = 0,
    RV32MSlow        = 1,
    RV32MFast        = 2,
    RV32MSingleCycle = 3
  } rv32m_e;

endpackage

// File: rtl/cve2_ex_ctrl_if.sv
// Issue (ID -> EX) and writeback (EX -> WB) handshakes of the EX-stage controller.
// The slave side is the controller; the master side is the ID/WB pipeline around it.
interface cve2_ex_ctrl_if;

  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_kind;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_result;

  modport slave (
    input  issue_valid,
    input  issue_kind,
    output issue_ready,
    output wb_valid,
    input  wb_ready,
    output wb_result
  );

  modport master (
    output issue_valid,
    output issue_kind,
    input  issue_ready,
    input  wb_valid,
    output wb_ready,
    input  wb_result
  );

endinterface

// File: rtl/cve2_ex_ctrl.sv
// EX-stage sequencer: takes one instruction at a time from ID, drives the
// ALU/MUL/DIV dynamic enables and first-cycle flag, owns the two-entry
// intermediate-value register, and holds the finished result in a one-entry
// output slot until writeback takes it. A watchdog aborts operations whose
// datapath never reports completion.
module cve2_ex_ctrl #(
  parameter cve2_pkg::rv32m_e RV32M       = cve2_pkg::RV32MFast,
  parameter int unsigned      MaxExCycles = 40
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  cve2_ex_ctrl_if.slave     ex_if,

  input  logic              flush_i,

  output logic              alu_instr_first_cycle_o,
  output logic              mult_en_o,
  output logic              div_en_o,
  output logic              multdiv_ready_id_o,

  input  logic              ex_valid_i,
  input  logic [31:0]       result_ex_i,

  input  logic [1:0]        imd_val_we_i,
  input  logic [1:0][33:0]  imd_val_d_i,
  output logic [1:0][33:0]  imd_val_q_o,

  output logic              busy_o,
  output logic              illegal_o,
  output logic              err_o
);

  localparam int unsigned     CntW    = $clog2(MaxExCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MaxExCycles - 1);
  localparam bit              MulDivEn = (RV32M != cve2_pkg::RV32MNone);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    KIND_ALU       = 2'b00,
    KIND_ALU_MULTI = 2'b01,
    KIND_MUL       = 2'b10,
    KIND_DIV       = 2'b11
  } kind_e;

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic [31:0]      result_q, result_d;
  logic [1:0][33:0] imd_val_q;
  logic             issue_ready;
  logic             accept;

  // A new instruction may enter when the controller is idle or when the held
  // result leaves this very cycle; nothing is accepted while a flush is active.
  assign issue_ready = ~flush_i & ((state_q == IDLE) | ((state_q == DONE) & ex_if.wb_ready));
  assign accept      = ex_if.issue_valid & issue_ready;

  assign ex_if.issue_ready = issue_ready;
  assign ex_if.wb_valid    = (state_q == DONE);
  assign ex_if.wb_result   = result_q;
  assign busy_o            = (state_q != IDLE);
  assign illegal_o         = illegal_q;
  assign imd_val_q_o       = imd_val_q;

  // Next-state, datapath enables, watchdog and result capture.
  always_comb begin
    state_d                 = state_q;
    kind_d                  = kind_q;
    cnt_d                   = cnt_q;
    illegal_d               = 1'b0;
    result_d                = result_q;
    alu_instr_first_cycle_o = 1'b0;
    mult_en_o               = 1'b0;
    div_en_o                = 1'b0;
    multdiv_ready_id_o      = 1'b0;
    err_o                   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      EXEC: begin
        // The counter is cleared on acceptance and only advances while the
        // instruction is still running, so zero marks the first EXEC cycle.
        alu_instr_first_cycle_o = (cnt_q == '0);
        mult_en_o               = (kind_q == KIND_MUL) & ~flush_i;
        div_en_o                = (kind_q == KIND_DIV) & ~flush_i;
        multdiv_ready_id_o      = 1'b1;
        if (flush_i) begin
          state_d = IDLE;
        end else if (ex_valid_i) begin
          result_d = result_ex_i;
          state_d  = DONE;
        end else if (cnt_q == CntLast) begin
          err_o   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        if (flush_i || ex_if.wb_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Acceptance happens only in IDLE or DONE and overrides the return to IDLE,
    // which gives back-to-back issue without a bubble.
    if (accept) begin
      kind_d = kind_e'(ex_if.issue_kind);
      cnt_d  = '0;
      if (ex_if.issue_kind[1] && !MulDivEn) begin
        illegal_d = 1'b1;
        state_d   = IDLE;
      end else begin
        state_d = EXEC;
      end
    end
  end

  // Control state, latched kind, watchdog counter, illegal pulse and result slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      kind_q    <= KIND_ALU;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      result_q  <= result_d;
    end
  end

  // Intermediate-value entries are written independently whenever EX asks,
  // regardless of state; multi-cycle ops seed them in their first cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      imd_val_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (imd_val_we_i[i]) begin
          imd_val_q[i] <= imd_val_d_i[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_cve2_ex_ctrl.sv
// Directed testbench for cve2_ex_ctrl: one controller with fast MUL/DIV and
// one built without MUL/DIV, driven through their handshake interfaces.
module tb_cve2_ex_ctrl;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             ex_valid;
  logic [31:0]      result_ex;
  logic [1:0]       imd_we;
  logic [1:0][33:0] imd_d;

  logic             first_f, mult_f, div_f, mdr_f, busy_f, ill_f, err_f;
  logic [1:0][33:0] imd_q_f;
  logic             first_n, mult_n, div_n, mdr_n, busy_n, ill_n, err_n;
  logic [1:0][33:0] imd_q_n;

  int checks;
  int errors;

  cve2_ex_ctrl_if bus_f ();
  cve2_ex_ctrl_if bus_n ();

  cve2_ex_ctrl #(
    .RV32M       (cve2_pkg::RV32MFast),
    .MaxExCycles (40)
  ) u_fast (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .ex_if                   (bus_f),
    .flush_i                 (flush),
    .alu_instr_first_cycle_o (first_f),
    .mult_en_o               (mult_f),
    .div_en_o                (div_f),
    .multdiv_ready_id_o      (mdr_f),
    .ex_valid_i              (ex_valid),
    .result_ex_i             (result_ex),
    .imd_val_we_i            (imd_we),
    .imd_val_d_i             (imd_d),
    .imd_val_q_o             (imd_q_f),
    .busy_o                  (busy_f),
    .illegal_o               (ill_f),
    .err_o                   (err_f)
  );

  cve2_ex_ctrl #(
    .RV32M       (cve2_pkg::RV32MNone),
    .MaxExCycles (40)
  ) u_none (
    .clk_i                   (clk),
    .rst_ni                  (rst_n),
    .ex_if                   (bus_n),
    .flush_i                 (flush),
    .alu_instr_first_cycle_o (first_n),
    .mult_en_o               (mult_n),
    .div_en_o                (div_n),
    .multdiv_ready_id_o      (mdr_n),
    .ex_valid_i              (ex_valid),
    .result_ex_i             (result_ex),
    .imd_val_we_i            (imd_we),
    .imd_val_d_i             (imd_d),
    .imd_val_q_o             (imd_q_n),
    .busy_o                  (busy_n),
    .illegal_o               (ill_n),
    .err_o                   (err_n)
  );

  // Free-running clock; rising edge is the active edge, inputs change on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to the next falling edge, where stimulus is applied.
  task automatic step();
    @(negedge clk);
  endtask

  // Reset values of every output on both controllers.
  task automatic test_reset();
    #1;
    checks++; if (bus_f.issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_issue_ready got %b exp 1", bus_f.issue_ready); end
    checks++; if (bus_f.wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid got %b exp 0", bus_f.wb_valid); end
    checks++; if (bus_f.wb_result !== 32'h0) begin errors++; $display("[TB] FAIL reset_wb_result got %h exp 0", bus_f.wb_result); end
    checks++; if ({busy_f, first_f, mult_f, div_f, mdr_f, ill_f, err_f} !== 7'b0) begin errors++; $display("[TB] FAIL reset_flags got %b exp 0000000", {busy_f, first_f, mult_f, div_f, mdr_f, ill_f, err_f}); end
    checks++; if (imd_q_f !== 68'h0) begin errors++; $display("[TB] FAIL reset_imd got %h exp 0", imd_q_f); end
    checks++; if ({bus_n.issue_ready, busy_n, ill_n} !== 3'b100) begin errors++; $display("[TB] FAIL reset_none got %b exp 100", {bus_n.issue_ready, busy_n, ill_n}); end
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Single-cycle ALU op: result visible two cycles after acceptance.
  task automatic test_alu_single();
    step(); bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b00; #1;
    checks++; if (bus_f.issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_issue_ready got %b exp 1", bus_f.issue_ready); end
    step(); bus_f.issue_valid = 1'b0; ex_valid = 1'b1; result_ex = 32'h1234_5678; #1;
    checks++; if ({busy_f, first_f, mdr_f, mult_f, div_f, bus_f.wb_valid} !== 6'b111000) begin errors++; $display("[TB] FAIL alu_exec got %b exp 111000", {busy_f, first_f, mdr_f, mult_f, div_f, bus_f.wb_valid}); end
    step(); ex_valid = 1'b0; #1;
    checks++; if (bus_f.wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL alu_wb_valid got %b exp 1", bus_f.wb_valid); end
    checks++; if (bus_f.wb_result !== 32'h1234_5678) begin errors++; $display("[TB] FAIL alu_wb_result got %h exp 12345678", bus_f.wb_result); end
    checks++; if (first_f !== 1'b0) begin errors++; $display("[TB] FAIL alu_first_done got %b exp 0", first_f); end
    bus_f.wb_ready = 1'b1; #1;
    checks++; if (bus_f.issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL alu_done_ready got %b exp 1", bus_f.issue_ready); end
    step(); bus_f.wb_ready = 1'b0; #1;
    checks++; if ({busy_f, bus_f.wb_valid} !== 2'b00) begin errors++; $display("[TB] FAIL alu_idle got %b exp 00", {busy_f, bus_f.wb_valid}); end
  endtask

  // DIV for 36 EXEC cycles, with intermediate-register writes along the way.
  task automatic test_div();
    int divHigh;
    int multHigh;
    int firstBad;
    divHigh = 0; multHigh = 0; firstBad = 0;
    step(); bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b11;
    for (int i = 0; i < 36; i++) begin
      step();
      bus_f.issue_valid = 1'b0;
      imd_we = 2'b00;
      if (i == 2) begin
        imd_we = 2'b11; imd_d[1] = 34'h3_0000_0001; imd_d[0] = 34'h1_2345_6789;
      end
      if (i == 4) begin
        imd_we = 2'b01; imd_d[1] = 34'h2_2222_2222; imd_d[0] = 34'h0_0000_00FF;
      end
      ex_valid = (i == 35);
      result_ex = 32'hCAFE_0036;
      #1;
      if (div_f === 1'b1) divHigh++;
      if (mult_f === 1'b1) multHigh++;
      if (first_f !== (i == 0)) firstBad++;
      if (i == 3) begin
        checks++; if (imd_q_f[1] !== 34'h3_0000_0001) begin errors++; $display("[TB] FAIL div_imd1 got %h exp 300000001", imd_q_f[1]); end
        checks++; if (imd_q_f[0] !== 34'h1_2345_6789) begin errors++; $display("[TB] FAIL div_imd0 got %h exp 123456789", imd_q_f[0]); end
      end
      if (i == 5) begin
        checks++; if (imd_q_f !== {34'h3_0000_0001, 34'h0_0000_00FF}) begin errors++; $display("[TB] FAIL div_imd_we01 got %h exp %h", imd_q_f, {34'h3_0000_0001, 34'h0_0000_00FF}); end
      end
    end
    step(); ex_valid = 1'b0; #1;
    checks++; if (divHigh !== 36) begin errors++; $display("[TB] FAIL div_en_cycles got %0d exp 36", divHigh); end
    checks++; if (multHigh !== 0) begin errors++; $display("[TB] FAIL div_mult_cycles got %0d exp 0", multHigh); end
    checks++; if (firstBad !== 0) begin errors++; $display("[TB] FAIL div_first_flag got %0d bad cycles exp 0", firstBad); end
    checks++; if ({bus_f.wb_valid, div_f} !== 2'b10) begin errors++; $display("[TB] FAIL div_done got %b exp 10", {bus_f.wb_valid, div_f}); end
    checks++; if (bus_f.wb_result !== 32'hCAFE_0036) begin errors++; $display("[TB] FAIL div_result got %h exp cafe0036", bus_f.wb_result); end
    bus_f.wb_ready = 1'b1;
    step(); bus_f.wb_ready = 1'b0;
  endtask

  // Result consumed and next instruction accepted in the same DONE cycle.
  task automatic test_back_to_back();
    step(); bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b00;
    step(); bus_f.issue_valid = 1'b0; ex_valid = 1'b1; result_ex = 32'hAAAA_0001;
    step(); ex_valid = 1'b0; #1;
    checks++; if (bus_f.wb_result !== 32'hAAAA_0001) begin errors++; $display("[TB] FAIL b2b_first_result got %h exp aaaa0001", bus_f.wb_result); end
    bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b01; bus_f.wb_ready = 1'b1; #1;
    checks++; if (bus_f.issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready got %b exp 1", bus_f.issue_ready); end
    step(); bus_f.issue_valid = 1'b0; bus_f.wb_ready = 1'b0; #1;
    checks++; if ({busy_f, bus_f.wb_valid, first_f} !== 3'b101) begin errors++; $display("[TB] FAIL b2b_exec got %b exp 101", {busy_f, bus_f.wb_valid, first_f}); end
    step(); #1;
    checks++; if ({busy_f, bus_f.wb_valid, first_f, mult_f} !== 4'b1000) begin errors++; $display("[TB] FAIL b2b_exec2 got %b exp 1000", {busy_f, bus_f.wb_valid, first_f, mult_f}); end
    ex_valid = 1'b1; result_ex = 32'hBBBB_0002;
    step(); ex_valid = 1'b0; #1;
    checks++; if ({bus_f.wb_valid, bus_f.wb_result} !== {1'b1, 32'hBBBB_0002}) begin errors++; $display("[TB] FAIL b2b_second got %b/%h exp 1/bbbb0002", bus_f.wb_valid, bus_f.wb_result); end
    bus_f.wb_ready = 1'b1;
    step(); bus_f.wb_ready = 1'b0; #1;
    checks++; if (busy_f !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got %b exp 0", busy_f); end
  endtask

  // Writeback stalls for five cycles while ID keeps offering a new instruction.
  task automatic test_backpressure();
    step(); bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b00;
    step(); bus_f.issue_valid = 1'b0; ex_valid = 1'b1; result_ex = 32'hC0DE_0005;
    step(); ex_valid = 1'b0; bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b00; bus_f.wb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus_f.wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_wb_valid_%0d got %b exp 1", i, bus_f.wb_valid); end
      checks++; if (bus_f.wb_result !== 32'hC0DE_0005) begin errors++; $display("[TB] FAIL bp_result_%0d got %h exp c0de0005", i, bus_f.wb_result); end
      checks++; if (bus_f.issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_issue_ready_%0d got %b exp 0", i, bus_f.issue_ready); end
      step();
    end
    bus_f.issue_valid = 1'b0; bus_f.wb_ready = 1'b1; #1;
    checks++; if (bus_f.wb_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_still_valid got %b exp 1", bus_f.wb_valid); end
    step(); bus_f.wb_ready = 1'b0; #1;
    checks++; if ({busy_f, bus_f.wb_valid} !== 2'b00) begin errors++; $display("[TB] FAIL bp_idle got %b exp 00", {busy_f, bus_f.wb_valid}); end
  endtask

  // MUL whose datapath never completes: err_o on the 40th EXEC cycle.
  task automatic test_watchdog();
    int multHigh;
    int errHigh;
    int errCycle;
    multHigh = 0; errHigh = 0; errCycle = 0;
    step(); bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b10;
    for (int k = 1; k <= 40; k++) begin
      step(); bus_f.issue_valid = 1'b0; #1;
      if (mult_f === 1'b1) multHigh++;
      if (err_f === 1'b1) begin errHigh++; errCycle = k; end
    end
    step(); #1;
    checks++; if (multHigh !== 40) begin errors++; $display("[TB] FAIL wd_mult_cycles got %0d exp 40", multHigh); end
    checks++; if (errHigh !== 1) begin errors++; $display("[TB] FAIL wd_err_pulses got %0d exp 1", errHigh); end
    checks++; if (errCycle !== 40) begin errors++; $display("[TB] FAIL wd_err_cycle got %0d exp 40", errCycle); end
    checks++; if ({busy_f, err_f, mult_f, bus_f.wb_valid} !== 4'b0000) begin errors++; $display("[TB] FAIL wd_after got %b exp 0000", {busy_f, err_f, mult_f, bus_f.wb_valid}); end
  endtask

  // Flush in EXEC beats a simultaneous ex_valid; flush in DONE drops the result.
  task automatic test_flush();
    step(); bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b10;
    step(); bus_f.issue_valid = 1'b0;
    step();
    step(); flush = 1'b1; ex_valid = 1'b1; result_ex = 32'hFFFF_0000; bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b00; #1;
    checks++; if ({mult_f, bus_f.issue_ready, busy_f, err_f} !== 4'b0010) begin errors++; $display("[TB] FAIL flush_exec got %b exp 0010", {mult_f, bus_f.issue_ready, busy_f, err_f}); end
    step(); flush = 1'b0; ex_valid = 1'b0; bus_f.issue_valid = 1'b0; #1;
    checks++; if ({busy_f, bus_f.wb_valid} !== 2'b00) begin errors++; $display("[TB] FAIL flush_exec_after got %b exp 00", {busy_f, bus_f.wb_valid}); end
    checks++; if (bus_f.wb_result !== 32'hC0DE_0005) begin errors++; $display("[TB] FAIL flush_result_kept got %h exp c0de0005", bus_f.wb_result); end
    step(); bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b00;
    step(); bus_f.issue_valid = 1'b0; ex_valid = 1'b1; result_ex = 32'h5555_AAAA;
    step(); ex_valid = 1'b0; flush = 1'b1; bus_f.wb_ready = 1'b1; #1;
    checks++; if ({bus_f.wb_valid, bus_f.issue_ready} !== 2'b10) begin errors++; $display("[TB] FAIL flush_done got %b exp 10", {bus_f.wb_valid, bus_f.issue_ready}); end
    step(); flush = 1'b0; bus_f.wb_ready = 1'b0; #1;
    checks++; if ({busy_f, bus_f.wb_valid} !== 2'b00) begin errors++; $display("[TB] FAIL flush_done_after got %b exp 00", {busy_f, bus_f.wb_valid}); end
  endtask

  // Controller without MUL/DIV: MUL and DIV raise a single illegal pulse.
  task automatic test_illegal();
    step(); bus_n.issue_valid = 1'b1; bus_n.issue_kind = 2'b10; #1;
    checks++; if (bus_n.issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL ill_ready got %b exp 1", bus_n.issue_ready); end
    step(); bus_n.issue_valid = 1'b0; #1;
    checks++; if ({ill_n, busy_n, mult_n, bus_n.wb_valid} !== 4'b1000) begin errors++; $display("[TB] FAIL ill_mul_pulse got %b exp 1000", {ill_n, busy_n, mult_n, bus_n.wb_valid}); end
    step(); #1;
    checks++; if ({ill_n, mult_n, bus_n.wb_valid} !== 3'b000) begin errors++; $display("[TB] FAIL ill_mul_after got %b exp 000", {ill_n, mult_n, bus_n.wb_valid}); end
    bus_n.issue_valid = 1'b1; bus_n.issue_kind = 2'b11;
    step(); bus_n.issue_valid = 1'b0; #1;
    checks++; if ({ill_n, busy_n, div_n} !== 3'b100) begin errors++; $display("[TB] FAIL ill_div_pulse got %b exp 100", {ill_n, busy_n, div_n}); end
    checks++; if (ill_f !== 1'b0) begin errors++; $display("[TB] FAIL ill_fast_quiet got %b exp 0", ill_f); end
    step();
  endtask

  // Asynchronous reset in the middle of a DIV clears everything at once.
  task automatic test_async_reset();
    step(); bus_f.issue_valid = 1'b1; bus_f.issue_kind = 2'b11;
    step(); bus_f.issue_valid = 1'b0;
    step(); #1;
    checks++; if ({div_f, busy_f} !== 2'b11) begin errors++; $display("[TB] FAIL ar_before got %b exp 11", {div_f, busy_f}); end
    checks++; if (imd_q_f !== {34'h3_0000_0001, 34'h0_0000_00FF}) begin errors++; $display("[TB] FAIL ar_imd_before got %h exp %h", imd_q_f, {34'h3_0000_0001, 34'h0_0000_00FF}); end
    #2 rst_n = 1'b0; #1;
    checks++; if ({div_f, busy_f, mdr_f, bus_f.issue_ready} !== 4'b0001) begin errors++; $display("[TB] FAIL ar_flags got %b exp 0001", {div_f, busy_f, mdr_f, bus_f.issue_ready}); end
    checks++; if ({imd_q_f, bus_f.wb_result} !== 100'h0) begin errors++; $display("[TB] FAIL ar_regs got %h exp 0", {imd_q_f, bus_f.wb_result}); end
    step(); step(); rst_n = 1'b1;
    step(); #1;
    checks++; if ({busy_f, bus_f.issue_ready} !== 2'b01) begin errors++; $display("[TB] FAIL ar_after got %b exp 01", {busy_f, bus_f.issue_ready}); end
  endtask

  // Sequence of directed scenarios followed by the summary.
  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; result_ex = 32'h0;
    imd_we = 2'b00; imd_d = '0;
    bus_f.issue_valid = 1'b0; bus_f.issue_kind = 2'b00; bus_f.wb_ready = 1'b0;
    bus_n.issue_valid = 1'b0; bus_n.issue_kind = 2'b00; bus_n.wb_ready = 1'b0;
    test_reset();
    test_alu_single();
    test_div();
    test_back_to_back();
    test_backpressure();
    test_watchdog();
    test_flush();
    test_illegal();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
